// File: rtl/control_fsm_pkg.sv
// Shared constants for the multicycle controller and ALU: state encoding, opcodes,
// funct codes, ALU operation codes and the bundled control-word type.
package control_fsm_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXEC  = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       pc_en;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [3:0] alu_con;
        logic       illegal_op;
    } ctrl_t;

    // All enables off; the ALU idles on add.
    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c         = '0;
        c.alu_con = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the R-type funct field onto an ALU operation code; flags unsupported functs.
module alu_decoder
    import control_fsm_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_con,
    output logic       o_illegal
);

    always_comb begin
        o_alu_con = ALU_ADD;
        o_illegal = 1'b0;
        case (i_funct)
            FN_ADD:  o_alu_con = ALU_ADD;
            FN_SUB:  o_alu_con = ALU_SUB;
            FN_AND:  o_alu_con = ALU_AND;
            FN_OR:   o_alu_con = ALU_OR;
            FN_SLT:  o_alu_con = ALU_SLT;
            FN_NOR:  o_alu_con = ALU_NOR;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Moore-style multicycle controller: sequences fetch, decode and per-instruction
// execute/memory/writeback states and drives the datapath enables and selects.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       PCEn,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUCon,
    output logic       IllegalOp
);

    logic [3:0] r_state;
    logic       r_is_sw;
    logic [3:0] w_next_state;
    logic [3:0] w_funct_alu_con;
    logic       w_funct_illegal;
    ctrl_t      w_ctrl;

    alu_decoder u_alu_decoder (
        .i_funct   (Funct),
        .o_alu_con (w_funct_alu_con),
        .o_illegal (w_funct_illegal)
    );

    // Load/store choice is captured in DECODE so later Op changes cannot redirect MEMADR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_is_sw <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_is_sw <= (Op == OP_SW);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  if (MemReady) w_next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_REXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = r_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (MemReady) w_next_state = S_MEMWB;
            S_MEMWR:  if (MemReady) w_next_state = S_FETCH;
            S_REXEC:  w_next_state = w_funct_illegal ? S_FETCH : S_RWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_MEMWB, S_ADDIWB, S_RWB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_ctrl = ctrl_default();
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = 2'b01;
                w_ctrl.ir_write  = MemReady;
                w_ctrl.pc_en     = MemReady;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = 2'b11;
                case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: w_ctrl.illegal_op = 1'b0;
                    default: w_ctrl.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            S_ADDIWB: w_ctrl.reg_write = 1'b1;
            S_REXEC: begin
                w_ctrl.alu_src_a  = 1'b1;
                w_ctrl.alu_con    = w_funct_alu_con;
                w_ctrl.illegal_op = w_funct_illegal;
            end
            S_RWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_con   = ALU_SUB;
                w_ctrl.pc_src    = 2'b01;
                w_ctrl.pc_en     = Zero;
            end
            S_JUMP: begin
                w_ctrl.pc_src = 2'b10;
                w_ctrl.pc_en  = 1'b1;
            end
            default: w_ctrl = ctrl_default();
        endcase

        // Reset masks every side effect immediately, leaving selects at fetch values.
        if (reset) begin
            w_ctrl           = ctrl_default();
            w_ctrl.alu_src_b = 2'b01;
        end
    end

    assign MemRead   = w_ctrl.mem_read;
    assign MemWrite  = w_ctrl.mem_write;
    assign IorD      = w_ctrl.iord;
    assign IRWrite   = w_ctrl.ir_write;
    assign RegWrite  = w_ctrl.reg_write;
    assign RegDst    = w_ctrl.reg_dst;
    assign MemtoReg  = w_ctrl.mem_to_reg;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign PCEn      = w_ctrl.pc_en;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign PCSrc     = w_ctrl.pc_src;
    assign ALUCon    = w_ctrl.alu_con;
    assign IllegalOp = w_ctrl.illegal_op;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Op, input, 6, instruction opcode from instruction register.
REQ-004 SHALL have port Funct, input, 6, R-type funct field.
REQ-005 SHALL have port Zero, input, 1, ALU zero flag.
REQ-006 SHALL have port MemReady, input, 1, memory completes read/write this cycle.
REQ-007 SHALL have outputs MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, PCEn, each 1 bit, datapath enables/selects.
REQ-008 SHALL have outputs ALUSrcB (2), PCSrc (2), ALUCon (4).
REQ-009 SHALL have output IllegalOp, 1, one-cycle pulse on unsupported opcode/funct.

Function
REQ-010 SHALL implement a Moore FSM, states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB.
REQ-011 SHALL, in FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCon=0010, PCSrc=00; IRWrite=PCEn=MemReady; advance to DECODE only when MemReady=1, else hold.
REQ-012 SHALL, in DECODE: ALUSrcA=0, ALUSrcB=11, ALUCon=0010 (branch target); next by Op: 100011/101011->MEMADR, 000000->REXEC, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, other->FETCH with IllegalOp=1.
REQ-013 SHALL, in MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUCon=0010; MEMADR->MEMRD (Op=100011) or MEMWR (Op=101011); ADDIEX->ADDIWB.
REQ-014 SHALL, in MEMRD: MemRead=1, IorD=1; hold until MemReady=1, then MEMWB.
REQ-015 SHALL, in MEMWR: MemWrite=1, IorD=1; hold until MemReady=1, then FETCH.
REQ-016 SHALL, in MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; in ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; both ->FETCH.
REQ-017 SHALL, in REXEC: ALUSrcA=1, ALUSrcB=00, ALUCon from Funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->0011; other Funct->0010, IllegalOp=1, next FETCH with no writeback; legal->RWB.
REQ-018 SHALL, in RWB: RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
REQ-019 SHALL, in BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCon=0110, PCSrc=01, PCEn=Zero (only combinational path from Zero); ->FETCH.
REQ-020 SHALL, in JUMP: PCSrc=10, PCEn=1; ->FETCH.
REQ-021 SHALL drive every output not listed for a state to 0 (ALUCon default 0010).
REQ-022 SHALL never assert MemRead and MemWrite together, nor RegWrite and PCEn in the same cycle.
REQ-023 SHALL sample Op/Funct only in DECODE/REXEC; changes elsewhere SHALL not alter sequencing.
REQ-024 SHALL give instruction latencies with MemReady always 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.

Reset
REQ-025 SHALL, when reset=1 at a rising edge, enter FETCH regardless of current state, aborting any instruction (including mid MEMRD/MEMWR wait).
REQ-026 SHALL, while reset=1, drive MemRead=0, MemWrite=0, IRWrite=0, RegWrite=0, PCEn=0, IllegalOp=0, others at FETCH values.
REQ-027 SHALL resume FETCH outputs per REQ-011 in the first cycle with reset=0.

Structure
REQ-028 SHALL place state encoding, opcode constants, funct constants and ALUCon codes in a shared package used also by the ALU.
REQ-029 SHALL isolate the Funct->ALUCon mapping in sub-module alu_decoder.

Verification
REQ-030 SHALL test add (Op=000000, Funct=100000), MemReady=1 -> FETCH,DECODE,REXEC(ALUCon=0010),RWB(RegWrite=1,RegDst=1) -> FETCH.
REQ-031 SHALL test lw with MemReady low 3 cycles in MEMRD -> MemRead=1,IorD=1 held 4 cycles, then MEMWB MemtoReg=1.
REQ-032 SHALL test beq with Zero=1 and Zero=0 -> BRANCH ALUCon=0110, PCEn=1 resp. 0, PCSrc=01.
REQ-033 SHALL test Op=111111 -> IllegalOp pulse in DECODE, next FETCH, no RegWrite/MemWrite.
REQ-034 SHALL test reset asserted during MEMWR wait -> MemWrite=0 that cycle, FETCH next.
REQ-035 SHALL check REQ-022 invariants every cycle via assertion over random Op/Funct/MemReady/Zero.
